// File: rtl/wb_arb_pkg.sv
// Shared types and sizes for the two-master Wishbone-style arbiter.
// Bus widths come from the project ADDR_SIZE/WORD_SIZE defines; fallbacks keep this slice standalone.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package wb_arb_pkg;

    localparam int ADDR_W = `ADDR_SIZE;
    localparam int WORD_W = `WORD_SIZE;

    // One-hot so the grant bits fall straight out of the state register.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'b001,
        ST_GRANT_M0 = 3'b010,
        ST_GRANT_M1 = 3'b100
    } state_e;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // Wide enough for TIMEOUT_CYCLES up to 255.
    localparam int TMR_W = 8;

endpackage

// File: rtl/wb_arb_timer.sv
// Bus-timeout counter: counts stalled granted cycles, flags expiry at TIMEOUT_CYCLES.
// Only built with WB_ARB_TIMEOUT_EN; otherwise this file is empty.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_timer
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == TMR_W'(TIMEOUT_CYCLES));

endmodule
`endif

// File: rtl/wb_arbiter.sv
// Two-master round-robin arbiter for one shared slave; one transfer per grant, 1-cycle arbitration.
// Optional bus timeout compiled in with WB_ARB_TIMEOUT_EN (default build: grant held until ack or cs drop).
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] M0_addr_i,
    input  logic [WORD_W-1:0] M0_wdata_i,
    input  logic              M0_cs_i,
    input  logic              M0_we_i,
    output logic [WORD_W-1:0] M0_rdata_o,
    output logic              M0_ack_o,
    output logic              M0_err_o,
    input  logic [ADDR_W-1:0] M1_addr_i,
    input  logic [WORD_W-1:0] M1_wdata_i,
    input  logic              M1_cs_i,
    input  logic              M1_we_i,
    output logic [WORD_W-1:0] M1_rdata_o,
    output logic              M1_ack_o,
    output logic              M1_err_o,
    output logic [ADDR_W-1:0] S_addr_o,
    output logic [WORD_W-1:0] S_wdata_o,
    output logic              S_cs_o,
    output logic              S_we_o,
    input  logic [WORD_W-1:0] S_rdata_i,
    input  logic              S_ack_i,
    output logic [1:0]        Grant_o
);

    state_e state_q;
    state_e state_d;
    logic   last_owner_q;
    logic   last_owner_d;

    logic gnt_m0;
    logic gnt_m1;
    logic owner_cs;
    logic expired;

    assign gnt_m0   = (state_q == ST_GRANT_M0);
    assign gnt_m1   = (state_q == ST_GRANT_M1);
    assign owner_cs = (gnt_m0 & M0_cs_i) | (gnt_m1 & M1_cs_i);

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .Clk      (Clk),
        .Rst      (Rst),
        .clr_i    (state_q == ST_IDLE),
        .inc_i    (owner_cs & ~S_ack_i & ~expired),
        .expired_o(expired)
    );

    // An ack landing on the expiry cycle wins, so err is suppressed then.
    assign M0_err_o = gnt_m0 & M0_cs_i & expired & ~S_ack_i;
    assign M1_err_o = gnt_m1 & M1_cs_i & expired & ~S_ack_i;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign expired        = 1'b0;
    assign M0_err_o       = 1'b0;
    assign M1_err_o       = 1'b0;
`endif

    assign S_cs_o    = owner_cs & ~expired;
    assign S_we_o    = (gnt_m0 & M0_we_i) | (gnt_m1 & M1_we_i);
    assign S_addr_o  = gnt_m0 ? M0_addr_i  : (gnt_m1 ? M1_addr_i  : '0);
    assign S_wdata_o = gnt_m0 ? M0_wdata_i : (gnt_m1 ? M1_wdata_i : '0);

    // Each master's return path sees only its own cs and the slave, never the other master.
    assign M0_rdata_o = gnt_m0 ? S_rdata_i : '0;
    assign M1_rdata_o = gnt_m1 ? S_rdata_i : '0;
    assign M0_ack_o   = gnt_m0 & M0_cs_i & S_ack_i;
    assign M1_ack_o   = gnt_m1 & M1_cs_i & S_ack_i;

    assign Grant_o = {gnt_m1, gnt_m0};

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ST_IDLE: begin
                if (M0_cs_i && M1_cs_i) begin
                    state_d = (last_owner_q == OWNER_M1) ? ST_GRANT_M0 : ST_GRANT_M1;
                end else if (M0_cs_i) begin
                    state_d = ST_GRANT_M0;
                end else if (M1_cs_i) begin
                    state_d = ST_GRANT_M1;
                end
            end
            ST_GRANT_M0: begin
                if (!M0_cs_i) begin
                    state_d = ST_IDLE;
                end else if (S_ack_i || expired) begin
                    state_d      = ST_IDLE;
                    last_owner_d = OWNER_M0;
                end
            end
            ST_GRANT_M1: begin
                if (!M1_cs_i) begin
                    state_d = ST_IDLE;
                end else if (S_ack_i || expired) begin
                    state_d      = ST_IDLE;
                    last_owner_d = OWNER_M1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset to M1 as last owner so the first tie goes to M0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWNER_M1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter: transaction-level round-robin model feeds an expected queue.
module tb_wb_arbiter;
    import wb_arb_pkg::*;

    localparam int TMO = 16;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic [ADDR_W-1:0] M0_addr_i = '0;
    logic [WORD_W-1:0] M0_wdata_i = '0;
    logic              M0_cs_i = 1'b0;
    logic              M0_we_i = 1'b0;
    logic [WORD_W-1:0] M0_rdata_o;
    logic              M0_ack_o;
    logic              M0_err_o;
    logic [ADDR_W-1:0] M1_addr_i = '0;
    logic [WORD_W-1:0] M1_wdata_i = '0;
    logic              M1_cs_i = 1'b0;
    logic              M1_we_i = 1'b0;
    logic [WORD_W-1:0] M1_rdata_o;
    logic              M1_ack_o;
    logic              M1_err_o;
    logic [ADDR_W-1:0] S_addr_o;
    logic [WORD_W-1:0] S_wdata_o;
    logic              S_cs_o;
    logic              S_we_o;
    logic [WORD_W-1:0] S_rdata_i = '0;
    logic              S_ack_i = 1'b0;
    logic [1:0]        Grant_o;

    wb_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clk(Clk), .Rst(Rst),
        .M0_addr_i(M0_addr_i), .M0_wdata_i(M0_wdata_i), .M0_cs_i(M0_cs_i), .M0_we_i(M0_we_i),
        .M0_rdata_o(M0_rdata_o), .M0_ack_o(M0_ack_o), .M0_err_o(M0_err_o),
        .M1_addr_i(M1_addr_i), .M1_wdata_i(M1_wdata_i), .M1_cs_i(M1_cs_i), .M1_we_i(M1_we_i),
        .M1_rdata_o(M1_rdata_o), .M1_ack_o(M1_ack_o), .M1_err_o(M1_err_o),
        .S_addr_o(S_addr_o), .S_wdata_o(S_wdata_o), .S_cs_o(S_cs_o), .S_we_o(S_we_o),
        .S_rdata_i(S_rdata_i), .S_ack_i(S_ack_i), .Grant_o(Grant_o)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit                m;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [WORD_W-1:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   last_served = 1'b1;   // model: 1 = M1 served last
    bit   expect_idle = 1'b0;
    bit   mon_en = 1'b0;
    int   slave_mode = 0;       // 0 normal, 1 never ack, 2 spurious ack in idle, 3 ack M1 only
    int   fixed_lat = -1;
    int   lat = 0;

    function automatic logic [WORD_W-1:0] slave_data(input logic [ADDR_W-1:0] a);
        logic [31:0] a32;
        a32 = 32'(a);
        if (a32 == 32'h100) return WORD_W'(32'hDEADBEEF);
        return WORD_W'(a32 * 32'h9E3779B1 + 32'h01234567);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Slave: random (or fixed) wait states, read data derived from the address it sees.
    initial forever begin
        @(posedge Clk);
        #2;
        if (!S_cs_o) begin
            S_ack_i   = (slave_mode == 2);
            S_rdata_i = '0;
            lat       = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
        end else if (slave_mode == 1 || (slave_mode == 3 && Grant_o != 2'b10)) begin
            S_ack_i = 1'b0;
        end else if (lat == 0) begin
            S_ack_i   = 1'b1;
            S_rdata_i = slave_data(S_addr_o);
        end else begin
            lat--;
            S_ack_i = 1'b0;
        end
    end

    // Monitor: cycle invariants plus scoreboard pop on every completed slave transfer.
    initial forever begin
        @(negedge Clk);
        if (mon_en && !Rst) begin
            if (!Grant_o[0]) check("nonowner_m0", {M0_ack_o, M0_err_o, |M0_rdata_o}, 0);
            if (!Grant_o[1]) check("nonowner_m1", {M1_ack_o, M1_err_o, |M1_rdata_o}, 0);
            if (Grant_o == 2'b00) check("idle_bus", {S_cs_o, S_we_o, |S_addr_o, |S_wdata_o}, 0);
            check("grant_not_both", Grant_o == 2'b11, 0);
            check("ack_only_on_xfer", M0_ack_o | M1_ack_o, S_cs_o & S_ack_i);
            if (expect_idle) begin
                check("idle_after_xfer", Grant_o, 2'b00);
                expect_idle = 1'b0;
            end
            if (S_cs_o && S_ack_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("xfer_grant", Grant_o, e.m ? 2'b10 : 2'b01);
                    check("xfer_addr", S_addr_o, e.addr);
                    check("xfer_we", S_we_o, e.we);
                    check("xfer_wdata", S_wdata_o, e.wdata);
                    if (e.m) begin
                        check("m1_ack", M1_ack_o, 1);
                        check("m1_rdata", M1_rdata_o, slave_data(e.addr));
                        check("m0_ack_other", M0_ack_o, 0);
                    end else begin
                        check("m0_ack", M0_ack_o, 1);
                        check("m0_rdata", M0_rdata_o, slave_data(e.addr));
                        check("m1_ack_other", M1_ack_o, 0);
                    end
                end
                expect_idle = 1'b1;
            end
        end
    end

    task automatic master_txn(input bit m, input logic [ADDR_W-1:0] a, input logic we,
                              input logic [WORD_W-1:0] d);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        if (m) begin
            M1_addr_i = a; M1_we_i = we; M1_wdata_i = d; M1_cs_i = 1'b1;
        end else begin
            M0_addr_i = a; M0_we_i = we; M0_wdata_i = d; M0_cs_i = 1'b1;
        end
        while (!done && n < 200) begin
            @(negedge Clk);
            done = m ? M1_ack_o : M0_ack_o;
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL txn_done m%0d: no ack within %0d cycles, ack required", m, n);
        end
        @(posedge Clk);
        #1;
        if (m) M1_cs_i = 1'b0; else M0_cs_i = 1'b0;
    endtask

    // Arbitration latency: idle during the request cycle, winner on the bus the next.
    task automatic lat_check(input bit first);
        @(negedge Clk);
        check("arb_idle_cycle", Grant_o, 2'b00);
        @(negedge Clk);
        check("arb_latency_grant", Grant_o, first ? 2'b10 : 2'b01);
        check("arb_latency_scs", S_cs_o, 1);
    endtask

    task automatic phase(input bit r0, input bit r1,
                         input logic [ADDR_W-1:0] a0, input logic we0, input logic [WORD_W-1:0] d0,
                         input logic [ADDR_W-1:0] a1, input logic we1, input logic [WORD_W-1:0] d1,
                         input int gap);
        exp_t e0;
        exp_t e1;
        bit   first;
        e0 = '{1'b0, a0, we0, d0};
        e1 = '{1'b1, a1, we1, d1};
        if (r0 && r1) begin
            first = ~last_served;
            if (!first) begin
                exp_q.push_back(e0); exp_q.push_back(e1); last_served = 1'b1;
            end else begin
                exp_q.push_back(e1); exp_q.push_back(e0); last_served = 1'b0;
            end
        end else if (r0) begin
            first = 1'b0; exp_q.push_back(e0); last_served = 1'b0;
        end else begin
            first = 1'b1; exp_q.push_back(e1); last_served = 1'b1;
        end
        fork
            if (r0) master_txn(1'b0, a0, we0, d0);
            if (r1) master_txn(1'b1, a1, we1, d1);
            lat_check(first);
        join
        repeat (gap) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        last_served = 1'b1;
        expect_idle = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        @(posedge Clk);
        @(negedge Clk);
        check("reset_outputs", {|M0_rdata_o, M0_ack_o, M0_err_o, |M1_rdata_o, M1_ack_o, M1_err_o,
                                |S_addr_o, |S_wdata_o, S_cs_o, S_we_o, Grant_o}, 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        mon_en = 1'b1;

        // M0 read of 0x100 with three wait states.
        fixed_lat = 3;
        phase(1, 0, ADDR_W'(32'h100), 1'b0, '0, '0, 1'b0, '0, 0);
        fixed_lat = -1;

        // Continuous tie after reset alternates M0, M1, M0, M1.
        do_reset();
        phase(1, 1, ADDR_W'(32'h10), 1'b0, '0, ADDR_W'(32'h14), 1'b0, '0, 0);
        phase(1, 1, ADDR_W'(32'h18), 1'b1, WORD_W'(32'h1), ADDR_W'(32'h1C), 1'b1, WORD_W'(32'h2), 0);

        // M1 write while M0 idle.
        phase(0, 1, '0, 1'b0, '0, ADDR_W'(32'h20), 1'b1, WORD_W'(32'h55AA), 1);

        // Spurious slave acks while idle must not reach either master.
        slave_mode = 2;
        repeat (3) begin
            @(negedge Clk);
            check("spurious_m0_ack", M0_ack_o, 0);
            check("spurious_m1_ack", M1_ack_o, 0);
        end
        @(posedge Clk);
        #1;
        slave_mode = 1;

        // M0 abandons its request mid-grant.
        M0_addr_i = ADDR_W'(32'h44);
        M0_cs_i = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check("drop_grant", Grant_o, 2'b01);
        @(posedge Clk);
        #1;
        M0_cs_i = 1'b0;
        @(negedge Clk);
        check("drop_scs", S_cs_o, 0);
        check("drop_no_ack_err", {M0_ack_o, M0_err_o}, 0);
        @(negedge Clk);
        check("drop_idle", Grant_o, 2'b00);

        // Reset during an M1 grant abandons the transfer; next tie goes to M0.
        @(posedge Clk);
        #1;
        M1_addr_i = ADDR_W'(32'h80);
        M1_cs_i = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check("rst_pre_grant", Grant_o, 2'b10);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        M1_cs_i = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        last_served = 1'b1;
        expect_idle = 1'b0;
        @(negedge Clk);
        check("rst_grant", Grant_o, 2'b00);
        check("rst_scs", S_cs_o, 0);
        check("rst_m1_ack", M1_ack_o, 0);
        slave_mode = 0;
        @(posedge Clk);
        #1;
        phase(1, 1, ADDR_W'($urandom), 1'b0, '0, ADDR_W'($urandom), 1'b1, WORD_W'($urandom), 0);

        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(1, 3);
            phase(k[0], k[1],
                  ADDR_W'($urandom), 1'($urandom_range(0, 1)), WORD_W'($urandom),
                  ADDR_W'($urandom), 1'($urandom_range(0, 1)), WORD_W'($urandom),
                  $urandom_range(0, 2));
        end

`ifdef WB_ARB_TIMEOUT_EN
        // Slave never answers M0: error after TMO stalled cycles, then pending M1 is served.
        do_reset();
        slave_mode = 3;
        exp_q.push_back('{1'b1, ADDR_W'(32'h300), 1'b0, '0});
        fork
            master_txn(1'b1, ADDR_W'(32'h300), 1'b0, '0);
            begin
                int n;
                n = 0;
                M0_addr_i = ADDR_W'(32'h200);
                M0_cs_i = 1'b1;
                while (!S_cs_o && n < 10) begin
                    @(negedge Clk);
                    n++;
                end
                n = 0;
                while (!M0_err_o && n < 100) begin
                    @(negedge Clk);
                    n++;
                end
                check("timeout_cycles", n, TMO);
                check("timeout_scs", S_cs_o, 0);
                check("timeout_ack", M0_ack_o, 0);
                @(posedge Clk);
                #1;
                M0_cs_i = 1'b0;
                @(negedge Clk);
                check("timeout_idle", Grant_o, 2'b00);
                @(negedge Clk);
                check("timeout_m1_next", Grant_o, 2'b10);
            end
        join
        last_served = 1'b1;
        slave_mode = 0;
`endif

        repeat (5) @(posedge Clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, number of granted cycles without S_ack before timeout (range 2..255).
REQ-002 Clk  input  1  clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 M0_addr/M0_wdata  input  `ADDR_SIZE/`WORD_SIZE  master 0 (core ctrl unit) address/write data.
REQ-005 M0_cs, M0_we  input  1  master 0 request, write enable.
REQ-006 M0_rdata  output  `WORD_SIZE; M0_ack, M0_err  output  1  master 0 read data, ack, timeout error.
REQ-007 M1_addr/M1_wdata/M1_cs/M1_we inputs, M1_rdata/M1_ack/M1_err outputs; widths as master 0; master 1 (DMA/debug).
REQ-008 S_addr  output  `ADDR_SIZE; S_wdata  output  `WORD_SIZE; S_cs, S_we  output  1  shared slave request.
REQ-009 S_rdata  input  `WORD_SIZE; S_ack  input  1  slave response.
REQ-010 Grant  output  2  one-hot current owner (bit0=M0, bit1=M1, 00=none).

Function
REQ-011 FSM states: ST_IDLE, ST_GRANT_M0, ST_GRANT_M1; one-hot encoded.
REQ-012 ST_IDLE: only M0_cs -> ST_GRANT_M0; only M1_cs -> ST_GRANT_M1; none -> stay.
REQ-013 Both requesting in ST_IDLE: grant the master not served last (round-robin); last_owner resets to M1 so M0 wins first tie.
REQ-014 Arbitration latency exactly 1 cycle: request seen in ST_IDLE, S_cs driven the following cycle.
REQ-015 In ST_GRANT_Mx: S_addr/S_we/S_wdata = Mx fields, S_cs = Mx_cs, Mx_rdata = S_rdata, Mx_ack = S_ack, all combinational.
REQ-016 Non-owner master: ack=0, err=0, rdata=0 every cycle.
REQ-017 ST_IDLE: S_addr, S_wdata, S_cs, S_we = 0; Grant = 00.
REQ-018 Cycle with S_ack=1 while granted: Mx_ack=1, last_owner<=x, next state ST_IDLE (one transfer per grant).
REQ-019 Owner drops Mx_cs before ack: S_cs=0 that cycle, next state ST_IDLE, no ack/err issued.
REQ-020 S_ack while in ST_IDLE or while S_cs=0: ignored, no master ack.
REQ-021 Back-to-back requests from the same master with the other idle: one ST_IDLE cycle between transfers.
REQ-022 Outputs are functions of registered state and current inputs only; no combinational path from M1 inputs to M0 outputs or vice versa.

Reset
REQ-023 On Rst: state<=ST_IDLE, last_owner<=M1, timeout counter<=0.
REQ-024 Cycle after Rst edge: all outputs 0, including mid-transfer (in-flight transfer abandoned, no ack).

Configuration
REQ-025 Macro WB_ARB_TIMEOUT_EN compiles in the bus timeout.
REQ-026 Defined: counter clears on grant entry, increments each granted cycle with S_cs=1 and S_ack=0; when it reaches TIMEOUT_CYCLES, Mx_err=1 and S_cs=0 for that cycle, last_owner<=x, next state ST_IDLE.
REQ-027 Defined: S_ack and timeout in same cycle -> ack wins, err=0.
REQ-028 Undefined: no counter logic, M0_err=M1_err=0 constant, grant held until ack or cs drop.

Structure
REQ-029 Package wb_arb_pkg: state enum typedef, owner index constants (OWNER_M0, OWNER_M1), timeout counter width; sizes from defines.svh.
REQ-030 Sub-module wb_arb_timer (counter + expiry flag) instantiated only under WB_ARB_TIMEOUT_EN.

Verification
REQ-031 M0 read 0x100, slave acks after 3 cycles, rdata 0xDEADBEEF -> S_cs one cycle after M0_cs, M0_ack with 0xDEADBEEF, M1_ack=0, Grant 01->00.
REQ-032 M0 and M1 request same cycle after reset, continuously -> order M0,M1,M0,M1 (4 transfers alternate), one idle cycle between each.
REQ-033 M1 write 0x55AA to 0x20 while M0 idle -> S_we=1, S_wdata=0x55AA, S_addr=0x20; M1_ack on S_ack.
REQ-034 With WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks M0 -> M0_err pulse exactly 16 granted cycles after S_cs rise, then M1 pending request granted next.
REQ-035 Rst asserted during M1 grant before ack -> next cycle Grant=00, S_cs=0, no M1_ack; next tie goes to M0.
REQ-036 Spurious S_ack in ST_IDLE -> no master ack; M0 drops cs mid-grant -> ST_IDLE, no ack/err.
